// File: rtl/addr_buff_pkg.sv
// addr_buff_pkg: shared definitions for the banked address buffer controller.
// Holds the drain FSM state encoding and the default geometry constants.
package addr_buff_pkg;

  localparam int SRAM_DEPTH_DEF = 1024;
  localparam int BAND_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

endpackage

// File: rtl/addr_buff_ctrl_if.sv
// addr_buff_ctrl_if: write lanes, drain control and banked SRAM port signals.
// The master side is the producer/consumer; the slave side is the controller.
interface addr_buff_ctrl_if
  import addr_buff_pkg::*;
#(
  parameter int SRAM_DEPTH = SRAM_DEPTH_DEF,
  parameter int BAND_WIDTH = BAND_WIDTH_DEF
);
  localparam int AW = $clog2(SRAM_DEPTH);
  localparam int BW = $clog2(BAND_WIDTH);

  logic [BAND_WIDTH-1:0]         wr_valid;
  logic                          start;
  logic                          rd_ready;
  logic [BAND_WIDTH-1:0]         wea;
  logic [BAND_WIDTH-1:0][AW-1:0] addra;
  logic                          enb;
  logic [AW+BW-1:0]              addrb;
  logic                          rd_valid;
  logic                          busy;
  logic                          done;

  modport master (
    output wr_valid, start, rd_ready,
    input  wea, addra, enb, addrb, rd_valid, busy, done
  );

  modport slave (
    input  wr_valid, start, rd_ready,
    output wea, addra, enb, addrb, rd_valid, busy, done
  );

endinterface

// File: rtl/addr_buff_bank_ptr.sv
// addr_buff_bank_ptr: write pointer and fill count for one SRAM bank.
// Writes are accepted only while the controller is idle and the bank has room;
// a full bank never wraps. Optional macro ADDR_BUFF_CTRL_OVF_EN exposes a
// per-bank drop indication used for the sticky overflow flag.
module addr_buff_bank_ptr
  import addr_buff_pkg::*;
#(
  parameter int SRAM_DEPTH = SRAM_DEPTH_DEF,
  localparam int AW = $clog2(SRAM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic          accept_en,
  input  logic          clear,
  output logic          wea,
`ifdef ADDR_BUFF_CTRL_OVF_EN
  output logic          drop,
`endif
  output logic [AW-1:0] wptr,
  output logic [AW:0]   cnt
);

  localparam int          AW1  = AW + 1;
  localparam logic [AW:0] FULL = AW1'(SRAM_DEPTH);

  assign wea = wr_valid && accept_en && (cnt < FULL);

`ifdef ADDR_BUFF_CTRL_OVF_EN
  assign drop = wr_valid && !wea;
`endif

  // Advance pointer and count on every accepted write; cleared after a drain.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr <= '0;
      cnt  <= '0;
    end else if (wea) begin
      wptr <= wptr + AW'(1);
      cnt  <= cnt + AW1'(1);
    end
  end

endmodule

// File: rtl/addr_buff_ctrl.sv
// addr_buff_ctrl: collects per-bank writes, then on start drains every stored
// entry bank by bank through a single read port with a valid/ready handshake.
// Optional macro ADDR_BUFF_CTRL_OVF_EN adds the sticky ovf port, which flags
// any write lane that had to be dropped.
module addr_buff_ctrl
  import addr_buff_pkg::*;
#(
  parameter int SRAM_DEPTH = SRAM_DEPTH_DEF,
  parameter int BAND_WIDTH = BAND_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  addr_buff_ctrl_if.slave   bus
`ifdef ADDR_BUFF_CTRL_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam int AW = $clog2(SRAM_DEPTH);
  localparam int BW = $clog2(BAND_WIDTH);

  state_t                        state;
  logic [BW-1:0]                 bank;
  logic [AW-1:0]                 offset;
  logic                          rd_valid_q;
  logic                          done_q;

  logic [AW:0]                   cnt [BAND_WIDTH];
  logic [BAND_WIDTH-1:0]         wea_v;
  logic [BAND_WIDTH-1:0][AW-1:0] addra_v;
  logic [BAND_WIDTH-1:0]         nonempty;
  logic                          cur_nonempty;
  logic                          higher_nonempty;
  logic                          last_in_bank;
  logic                          stall;
  logic                          enb_c;

`ifdef ADDR_BUFF_CTRL_OVF_EN
  logic [BAND_WIDTH-1:0]         drop;
`endif

  for (genvar i = 0; i < BAND_WIDTH; i++) begin : g_bank
    addr_buff_bank_ptr #(
      .SRAM_DEPTH (SRAM_DEPTH)
    ) u_bank_ptr (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (bus.wr_valid[i]),
      .accept_en (state == S_IDLE),
      .clear     (state == S_DONE),
      .wea       (wea_v[i]),
`ifdef ADDR_BUFF_CTRL_OVF_EN
      .drop      (drop[i]),
`endif
      .wptr      (addra_v[i]),
      .cnt       (cnt[i])
    );
    assign nonempty[i] = (cnt[i] != '0);
  end

  assign cur_nonempty    = nonempty[bank];
  assign higher_nonempty = |((nonempty >> bank) >> 1);
  assign last_in_bank    = (({1'b0, offset} + (AW + 1)'(1)) == cnt[bank]);
  assign stall           = rd_valid_q && !bus.rd_ready;
  assign enb_c           = (state == S_DRAIN) && cur_nonempty && !stall;

  assign bus.wea      = wea_v;
  assign bus.addra    = addra_v;
  assign bus.enb      = enb_c;
  assign bus.addrb    = {bank, offset};
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = done_q;

  // Drain sequencer: walks banks in order, holds position while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bank       <= '0;
      offset     <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == S_DONE);

      if (enb_c) begin
        rd_valid_q <= 1'b1;
      end else if (bus.rd_ready) begin
        rd_valid_q <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          bank   <= '0;
          offset <= '0;
          if (bus.start) begin
            state <= (|nonempty) ? S_DRAIN : S_DONE;
          end
        end
        S_DRAIN: begin
          if (!stall) begin
            if (!cur_nonempty || last_in_bank) begin
              offset <= '0;
              if (higher_nonempty) begin
                bank <= bank + BW'(1);
              end else begin
                state <= S_FLUSH;
              end
            end else begin
              offset <= offset + AW'(1);
            end
          end
        end
        S_FLUSH: begin
          if (!rd_valid_q || bus.rd_ready) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          bank   <= '0;
          offset <= '0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ADDR_BUFF_CTRL_OVF_EN
  // Sticky record of any write lane that could not be stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (|drop) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/addr_buff_ctrl.md
ADDR_BUFF_CTRL -- requirements
Module: addr_buff_ctrl

Interface
REQ-001 SHALL have parameter SRAM_DEPTH, default 1024, meaning entries per bank.
REQ-002 SHALL have parameter BAND_WIDTH, default 16, meaning number of banks/lanes; AW=$clog2(SRAM_DEPTH), BW=$clog2(BAND_WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_valid  input  BAND_WIDTH  lane i presents one entry for bank i this cycle.
REQ-006 SHALL have port start  input  1  single-cycle pulse requesting drain of all stored entries.
REQ-007 SHALL have port rd_ready  input  1  consumer accepts current read data.
REQ-008 SHALL have port wea  output  BAND_WIDTH  per-bank write enable.
REQ-009 SHALL have port addra  output  BAND_WIDTH x AW  per-bank write address.
REQ-010 SHALL have port enb  output  1  shared read enable.
REQ-011 SHALL have port addrb  output  AW+BW  read address {bank, offset}.
REQ-012 SHALL have port rd_valid  output  1  banked read data valid this cycle.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at drain completion.
REQ-015 SHALL have port ovf  output  1  sticky error flag (present only under ADDR_BUFF_CTRL_OVF_EN).

Function
REQ-016 SHALL keep per-bank write pointer wptr[i] (AW bits) and count cnt[i] (AW+1 bits).
REQ-017 SHALL drive wea[i]=wr_valid[i] && state==IDLE && cnt[i]<SRAM_DEPTH, addra[i]=wptr[i] combinationally; on wea[i] increment wptr[i] and cnt[i].
REQ-018 SHALL drop wr_valid[i] when bank full or state!=IDLE; no wrap-around write.
REQ-019 SHALL implement FSM IDLE, DRAIN, FLUSH, DONE.
REQ-020 IDLE->DRAIN on start if any cnt[i]!=0; IDLE->DONE on start if all counts zero; start outside IDLE ignored.
REQ-021 DRAIN SHALL visit banks 0..BAND_WIDTH-1 ascending, offsets 0..cnt[b]-1 per bank; an empty bank costs exactly one cycle with enb=0.
REQ-022 SHALL assert enb only in DRAIN when !(rd_valid && !rd_ready); addrb={bank,offset} of the issued read.
REQ-023 SHALL set rd_valid one cycle after an enb cycle (SRAM latency 1); rd_valid held with data stable while rd_ready low; cleared after accept with no new enb.
REQ-024 Issuing last entry of last nonempty bank SHALL move DRAIN->FLUSH; FLUSH->DONE when rd_valid && rd_ready (or rd_valid low).
REQ-025 DONE SHALL pulse done for one cycle, clear all wptr/cnt, return to IDLE next cycle.
REQ-026 Latency: start at cycle 0 with bank 0 nonempty -> enb at cycle 1, rd_valid at cycle 2; full-rate throughput one entry/cycle with rd_ready high.

Reset
REQ-027 On rst: state=IDLE, all wptr/cnt=0, wea=0, enb=0, addrb=0, rd_valid=0, busy=0, done=0, ovf=0; rst mid-drain SHALL abandon drain without done pulse.

Configuration
REQ-028 With ADDR_BUFF_CTRL_OVF_EN defined, ovf SHALL set on any dropped wr_valid bit (full or non-IDLE) and clear only on rst; without it, port ovf and its logic SHALL be absent.

Structure
REQ-029 Shared package addr_buff_pkg SHALL hold the FSM state enum and default SRAM_DEPTH/BAND_WIDTH constants.
REQ-030 Per-bank pointer/count logic SHALL be one sub-module addr_buff_bank_ptr instantiated BAND_WIDTH times.

Verification
REQ-031 Write 3 entries bank 0, 2 bank 5, start, rd_ready=1 -> addrb 0x0000,0x0001,0x0002,0x1400,0x1401 with banks 1-4 one idle cycle each, done after last rd_valid.
REQ-032 Start with all banks empty -> done pulse at cycle 2, no enb.
REQ-033 rd_ready low 4 cycles mid-drain -> enb low, rd_valid and addrb held, no entry lost or duplicated.
REQ-034 Write 1025 entries to bank 3 -> wea low on 1025th, cnt[3]=1024; ovf=1 with macro.
REQ-035 wr_valid during DRAIN -> wea stays 0, counts unchanged; ovf=1 with macro.
REQ-036 rst asserted during DRAIN -> next cycle IDLE, all outputs zero, no done.
